// File: rtl/bus_addr_decoder_pkg.sv
// Shared types and default constants for the bus address decoder slice.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } bus_dec_state_t;

  localparam int BUS_ADDR_W  = 8;
  localparam int BUS_SEL_LSB = 5;
  localparam int BUS_SEL_W   = 2;
  localparam int BUS_N_SLV   = 3;
  localparam int BUS_TIMEOUT = 15;

endpackage

// File: rtl/bus_addr_decoder_if.sv
// Master-side request/completion signals plus per-slave select/acknowledge.
// The decoder connects through the slave modport; the bus master (or a
// testbench standing in for it and for the slaves) uses the master modport.
interface bus_addr_decoder_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int N_SLV  = BUS_N_SLV
);

  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic              m_busy;
  logic              m_ack;
  logic              m_err;
  logic [N_SLV-1:0]  s_sel;
  logic [N_SLV-1:0]  s_ack;

  modport master (
    output m_req, m_addr, s_ack,
    input  m_busy, m_ack, m_err, s_sel
  );

  modport slave (
    input  m_req, m_addr, s_ack,
    output m_busy, m_ack, m_err, s_sel
  );

endinterface

// File: rtl/bus_addr_decoder_timeout_cnt.sv
// Saturating ACTIVE-cycle counter; expired flags the last allowed cycle.
// Only instantiated when BUS_ADDR_DECODER_TIMEOUT_EN is defined.
module bus_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count up while enabled, holding at the last value instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/bus_addr_decoder.sv
// Registered address decoder / transaction tracker for one master and
// N_SLV slaves. Optional timeout path enabled by BUS_ADDR_DECODER_TIMEOUT_EN;
// without it ACTIVE waits for the selected slave indefinitely.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int SEL_LSB = BUS_SEL_LSB,
  parameter int SEL_W   = BUS_SEL_W,
  parameter int N_SLV   = BUS_N_SLV,
  parameter int TIMEOUT = BUS_TIMEOUT
) (
  input logic              clk,
  input logic              reset_n,
  bus_addr_decoder_if.slave bus
);

  bus_dec_state_t   state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N_SLV-1:0] s_sel_q, s_sel_d;
  logic             m_ack_q, m_ack_d;
  logic             m_err_q, m_err_d;
  logic             m_busy_q, m_busy_d;

  logic [SEL_W-1:0] reqIdx;
  logic             reqMapped;
  logic             ackHit;
  logic             timeoutHit;
  logic             errCause;

  assign reqIdx    = bus.m_addr[SEL_LSB +: SEL_W];
  assign reqMapped = (int'(reqIdx) < N_SLV);

  // Only the acknowledge of the latched slave counts, and only in ACTIVE.
  always_comb begin
    ackHit = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if ((state_q == ACTIVE) && (idx_q == SEL_W'(i)) && bus.s_ack[i]) begin
        ackHit = 1'b1;
      end
    end
  end

`ifdef BUS_ADDR_DECODER_TIMEOUT_EN
  logic timerClr;
  logic timerEn;

  assign timerClr = (state_q != ACTIVE);
  assign timerEn  = (state_q == ACTIVE) && !ackHit;

  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (timerClr),
    .en      (timerEn),
    .expired (timeoutHit)
  );
`else
  assign timeoutHit = 1'b0;
`endif

  // State register and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      s_sel_q  <= '0;
      m_ack_q  <= 1'b0;
      m_err_q  <= 1'b0;
      m_busy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      s_sel_q  <= s_sel_d;
      m_ack_q  <= m_ack_d;
      m_err_q  <= m_err_d;
      m_busy_q <= m_busy_d;
    end
  end

  // Next state: accept in IDLE, finish on acknowledge (wins over timeout).
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    errCause = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.m_req) begin
          if (reqMapped) begin
            idx_d   = reqIdx;
            state_d = ACTIVE;
          end else begin
            state_d  = DONE;
            errCause = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (ackHit) begin
          state_d = DONE;
        end else if (timeoutHit) begin
          state_d  = DONE;
          errCause = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next-values derived from where the FSM is heading.
  always_comb begin
    m_busy_d = (state_d != IDLE);
    m_ack_d  = (state_d == DONE);
    m_err_d  = (state_d == DONE) && errCause;
    s_sel_d  = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if ((state_d == ACTIVE) && (idx_d == SEL_W'(i))) begin
        s_sel_d[i] = 1'b1;
      end
    end
  end

  assign bus.s_sel  = s_sel_q;
  assign bus.m_ack  = m_ack_q;
  assign bus.m_err  = m_err_q;
  assign bus.m_busy = m_busy_q;

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Self-checking bench for bus_addr_decoder with default parameters.
// Timeout scenarios run only when BUS_ADDR_DECODER_TIMEOUT_EN is defined.
module tb_bus_addr_decoder;

  localparam int MODEL_N_SLV   = 3;
  localparam int MODEL_TIMEOUT = 15;
`ifdef BUS_ADDR_DECODER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;

  int checks;
  int errors;

  bus_addr_decoder_if #(.ADDR_W(8), .N_SLV(3)) bus ();

  bus_addr_decoder #(
    .ADDR_W  (8),
    .SEL_LSB (5),
    .SEL_W   (2),
    .N_SLV   (3),
    .TIMEOUT (15)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: phase 0 idle, 1 waiting on slave, 2 done.
  int  mPhase;
  int  mTarget;
  int  mAge;
  bit  mErr;
  bit  modelValid;
  int  region;

  initial begin
    mPhase     = 0;
    mTarget    = 0;
    mAge       = 0;
    mErr       = 1'b0;
    modelValid = 1'b0;
  end

  // Advance the reference on every rising edge from the inputs it sees.
  always @(posedge clk) begin
    if (!reset_n) begin
      mPhase     = 0;
      mAge       = 0;
      mErr       = 1'b0;
      modelValid = 1'b1;
    end else begin
      case (mPhase)
        0: begin
          if (bus.m_req) begin
            region = (int'(bus.m_addr) / 32) % 4;
            if (region < MODEL_N_SLV) begin
              mPhase  = 1;
              mTarget = region;
              mAge    = 0;
              mErr    = 1'b0;
            end else begin
              mPhase = 2;
              mErr   = 1'b1;
            end
          end
        end
        1: begin
          if (bus.s_ack[mTarget]) begin
            mPhase = 2;
            mErr   = 1'b0;
          end else if (TO_EN && (mAge + 1 >= MODEL_TIMEOUT)) begin
            mPhase = 2;
            mErr   = 1'b1;
          end else begin
            mAge = mAge + 1;
          end
        end
        default: begin
          mPhase = 0;
        end
      endcase
    end
  end

  // Compare every output against the reference on each falling edge.
  always @(negedge clk) begin
    logic [2:0] expSel;
    if (modelValid) begin
      expSel = (mPhase == 1) ? 3'(1 << mTarget) : 3'b000;
      checks = checks + 4;
      if (bus.s_sel !== expSel) begin
        errors = errors + 1;
        $display("[TB] FAIL model_s_sel t=%0t got %b expected %b", $time, bus.s_sel, expSel);
      end
      if (bus.m_ack !== (mPhase == 2)) begin
        errors = errors + 1;
        $display("[TB] FAIL model_m_ack t=%0t got %b expected %b", $time, bus.m_ack, (mPhase == 2));
      end
      if (bus.m_err !== ((mPhase == 2) && mErr)) begin
        errors = errors + 1;
        $display("[TB] FAIL model_m_err t=%0t got %b expected %b", $time, bus.m_err, ((mPhase == 2) && mErr));
      end
      if (bus.m_busy !== (mPhase != 0)) begin
        errors = errors + 1;
        $display("[TB] FAIL model_m_busy t=%0t got %b expected %b", $time, bus.m_busy, (mPhase != 0));
      end
    end
  end

  // Drive all bench-controlled inputs at once.
  task automatic applyStimulus(input logic rstN, input logic req,
                               input logic [7:0] addr, input logic [2:0] ack);
    reset_n    = rstN;
    bus.m_req  = req;
    bus.m_addr = addr;
    bus.s_ack  = ack;
  endtask

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Compare one observed value against a hand-computed literal.
  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    int cnt;
    checks = 0;
    errors = 0;

    // Reset held two cycles with a request pending.
    applyStimulus(1'b0, 1'b1, 8'h25, 3'b000);
    step();
    step();
    checkOutput("rst_s_sel", 8'(bus.s_sel), 8'h0);
    checkOutput("rst_m_ack", 8'(bus.m_ack), 8'h0);
    checkOutput("rst_m_err", 8'(bus.m_err), 8'h0);
    checkOutput("rst_m_busy", 8'(bus.m_busy), 8'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
    step();

    // Mapped access to slave 1, fastest acknowledge; address changes after latch.
    applyStimulus(1'b1, 1'b1, 8'h25, 3'b000);
    step();
    checkOutput("map_sel_c1", 8'(bus.s_sel), 8'h02);
    checkOutput("map_busy_c1", 8'(bus.m_busy), 8'h1);
    checkOutput("map_ack_c1", 8'(bus.m_ack), 8'h0);
    applyStimulus(1'b1, 1'b0, 8'h60, 3'b010);
    step();
    checkOutput("map_ack_c2", 8'(bus.m_ack), 8'h1);
    checkOutput("map_err_c2", 8'(bus.m_err), 8'h0);
    checkOutput("map_sel_c2", 8'(bus.s_sel), 8'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
    step();
    checkOutput("map_busy_c3", 8'(bus.m_busy), 8'h0);

    // Request held high through DONE is re-accepted one cycle later.
    applyStimulus(1'b1, 1'b1, 8'h41, 3'b000);
    step();
    checkOutput("hold_sel_c1", 8'(bus.s_sel), 8'h04);
    applyStimulus(1'b1, 1'b1, 8'h41, 3'b100);
    step();
    checkOutput("hold_ack_c2", 8'(bus.m_ack), 8'h1);
    applyStimulus(1'b1, 1'b1, 8'h41, 3'b000);
    step();
    checkOutput("hold_idle_c3", 8'(bus.m_busy), 8'h0);
    step();
    checkOutput("hold_sel_c4", 8'(bus.s_sel), 8'h04);
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b100);
    step();
    checkOutput("hold_ack_c5", 8'(bus.m_ack), 8'h1);
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
    step();

    // Unmapped region answered locally with an error.
    applyStimulus(1'b1, 1'b1, 8'h60, 3'b111);
    step();
    checkOutput("unm_sel", 8'(bus.s_sel), 8'h0);
    checkOutput("unm_ack", 8'(bus.m_ack), 8'h1);
    checkOutput("unm_err", 8'(bus.m_err), 8'h1);
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
    step();
    checkOutput("unm_idle", 8'(bus.m_busy), 8'h0);

`ifdef BUS_ADDR_DECODER_TIMEOUT_EN
    // Only an unselected slave acknowledges, so the request times out.
    applyStimulus(1'b1, 1'b1, 8'h00, 3'b000);
    step();
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b100);
    cnt = 0;
    while ((bus.s_sel == 3'b001) && (cnt < 40)) begin
      cnt = cnt + 1;
      step();
    end
    checkOutput("to_sel_cycles", 8'(cnt), 8'd15);
    checkOutput("to_ack", 8'(bus.m_ack), 8'h1);
    checkOutput("to_err", 8'(bus.m_err), 8'h1);
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
    step();

    // Acknowledge in the last allowed ACTIVE cycle wins over the timeout.
    applyStimulus(1'b1, 1'b1, 8'h05, 3'b000);
    step();
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
    for (int k = 0; k < 14; k++) step();
    checkOutput("last_sel_c15", 8'(bus.s_sel), 8'h01);
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b001);
    step();
    checkOutput("last_ack", 8'(bus.m_ack), 8'h1);
    checkOutput("last_err", 8'(bus.m_err), 8'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
    step();
`else
    // With no timer, a wrong-slave acknowledge just leaves ACTIVE waiting.
    applyStimulus(1'b1, 1'b1, 8'h00, 3'b000);
    step();
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b100);
    for (int k = 0; k < 30; k++) step();
    checkOutput("wait_sel", 8'(bus.s_sel), 8'h01);
    checkOutput("wait_ack", 8'(bus.m_ack), 8'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b001);
    step();
    checkOutput("wait_done_ack", 8'(bus.m_ack), 8'h1);
    checkOutput("wait_done_err", 8'(bus.m_err), 8'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
    step();
`endif

    // Reset in ACTIVE aborts without a completion, then a new request works.
    applyStimulus(1'b1, 1'b1, 8'h25, 3'b000);
    step();
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
    step();
    applyStimulus(1'b0, 1'b0, 8'h00, 3'b000);
    step();
    checkOutput("abort_sel", 8'(bus.s_sel), 8'h0);
    checkOutput("abort_busy", 8'(bus.m_busy), 8'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
    step();
    checkOutput("abort_no_ack", 8'(bus.m_ack), 8'h0);
    applyStimulus(1'b1, 1'b1, 8'h41, 3'b000);
    step();
    checkOutput("post_sel", 8'(bus.s_sel), 8'h04);
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b100);
    step();
    checkOutput("post_ack", 8'(bus.m_ack), 8'h1);
    checkOutput("post_err", 8'(bus.m_err), 8'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 3'b000);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
